// File: rtl/display_pkg.sv
// Shared constants, the converter state type and the decimal range helper
// for the numeric readout.
package display_pkg;

  localparam int CHAR_W = 16;
  localparam int CHAR_H = 32;
  localparam logic [3:0] DASH_CODE = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_t;

  function automatic int MAX_VALUE(input int digits);
    int m;
    m = 1;
    for (int i = 0; i < digits; i++) m = m * 10;
    return m - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter with a one-deep last-wins request buffer.
// commit is high for the single cycle in which bcd/ovf hold the finished result.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int DIGITS  = 3,
  parameter int VALUE_W = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  value_valid,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic                  commit
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (VALUE_W < 2) ? 1 : $clog2(VALUE_W);
  localparam int MAX_V = MAX_VALUE(DIGITS);

  state_t             state;
  state_t             state_nxt;
  logic [VALUE_W-1:0] bin;
  logic [VALUE_W-1:0] pend_value;
  logic [VALUE_W-1:0] load_value;
  logic [CNT_W-1:0]   cnt;
  logic               pend_valid;
  logic               ovf_flag;
  logic               start;
  logic               last_shift;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  assign load_value = pend_valid ? pend_value : value;
  assign start      = (state == ST_IDLE) && (pend_valid || value_valid);
  assign last_shift = (cnt == CNT_W'(VALUE_W - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_SHIFT;
      ST_SHIFT:  if (last_shift) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pend_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) cnt <= '0;
      else if (state == ST_SHIFT) cnt <= cnt + 1'b1;
      // A request arriving while the pending slot is consumed refills it.
      if (start && pend_valid) pend_valid <= value_valid;
      else if (value_valid && (state != ST_IDLE)) pend_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      bin      <= load_value;
      bcd      <= '0;
      ovf_flag <= int'(load_value) > MAX_V;
    end else if (state == ST_SHIFT) begin
      {bcd, bin} <= {add3(bcd), bin} << 1;
    end
    if (value_valid && ((state != ST_IDLE) || pend_valid)) pend_value <= value;
  end

  assign busy   = (state != ST_IDLE);
  assign commit = (state == ST_COMMIT);
  assign ovf    = ovf_flag;

endmodule

// File: rtl/font16x32.sv
// Seven-segment style 16x32 glyph renderer for digits 0-9 and a dash.
// on_char is high when (x, y) falls on a lit stroke of the glyph at (X0, Y0).
module font16x32
  import display_pkg::*;
#(
  parameter int X0 = 0,
  parameter int Y0 = 0
) (
  input  logic [3:0] code,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       on_char
);

  logic [9:0] lx;
  logic [9:0] ly;
  logic [6:0] seg;
  int         px;
  int         py;

  function automatic logic in_rect(input int cx, input int cy, input int xa,
                                   input int xb, input int ya, input int yb);
    return (cx >= xa) && (cx <= xb) && (cy >= ya) && (cy <= yb);
  endfunction

  // Wrapping subtraction makes columns left of / rows above the cell land out of range.
  assign lx = x - 10'(X0);
  assign ly = y - 10'(Y0);
  assign px = int'(lx);
  assign py = int'(ly);

  always_comb begin
    seg = 7'h00;
    case (code)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      4'hA:    seg = 7'h40;
      default: seg = 7'h00;
    endcase
  end

  always_comb begin
    on_char = 1'b0;
    if ((px < CHAR_W) && (py < CHAR_H)) begin
      on_char = (seg[0] && in_rect(px, py, 3, 12, 1, 3))
             || (seg[1] && in_rect(px, py, 12, 14, 3, 15))
             || (seg[2] && in_rect(px, py, 12, 14, 16, 28))
             || (seg[3] && in_rect(px, py, 3, 12, 28, 30))
             || (seg[4] && in_rect(px, py, 1, 3, 16, 28))
             || (seg[5] && in_rect(px, py, 1, 3, 3, 15))
             || (seg[6] && in_rect(px, py, 3, 12, 14, 16));
    end
  end

endmodule

// File: rtl/numeric_display.sv
// On-screen decimal readout: converts a binary value to BCD, then draws the
// committed digits with leading-zero blanking and a dashed overflow indication.
module numeric_display
  import display_pkg::*;
#(
  parameter int X1       = 0,
  parameter int Y1       = 0,
  parameter int DIGITS   = 3,
  parameter int VALUE_W  = 10,
  parameter int BLANK_LZ = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [VALUE_W-1:0] value,
  input  logic               value_valid,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic               on_display
);

  localparam logic [DIGITS-1:0] RESET_MASK =
    (BLANK_LZ != 0) ? DIGITS'(1) : {DIGITS{1'b1}};

  logic [4*DIGITS-1:0]       bcd;
  logic                      ovf;
  logic                      commit;
  logic [DIGITS-1:0][3:0]    digits;
  logic [DIGITS-1:0]         mask;
  logic [DIGITS-1:0]         lz_mask;
  logic [DIGITS-1:0]         glyph_on;
  logic                      seen;

  bin2bcd_seq #(
    .DIGITS  (DIGITS),
    .VALUE_W (VALUE_W)
  ) u_conv (
    .clk         (clk),
    .reset_n     (reset_n),
    .value       (value),
    .value_valid (value_valid),
    .busy        (busy),
    .bcd         (bcd),
    .ovf         (ovf),
    .commit      (commit)
  );

  // Scan from the most significant digit: a digit is kept once any digit at or above it is nonzero.
  always_comb begin
    seen    = 1'b0;
    lz_mask = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen       = seen | (bcd[4*i +: 4] != 4'd0);
      lz_mask[i] = seen | (i == 0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      digits   <= '0;
      mask     <= RESET_MASK;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= commit;
      if (commit) begin
        overflow <= ovf;
        digits   <= ovf ? {DIGITS{DASH_CODE}} : bcd;
        mask     <= (ovf || (BLANK_LZ == 0)) ? {DIGITS{1'b1}} : lz_mask;
      end
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    font16x32 #(
      .X0 (X1 + (DIGITS - 1 - i) * CHAR_W),
      .Y0 (Y1)
    ) u_font (
      .code    (digits[i]),
      .x       (x),
      .y       (y),
      .on_char (glyph_on[i])
    );
  end

  assign on_display = |(glyph_on & mask);

endmodule

// File: tb/tb_numeric_display.sv
// Bench for numeric_display: two instances (blanking on/off) share stimulus and
// are checked every cycle against a decimal-arithmetic model of the readout.
module tb_numeric_display;

  localparam int X1 = 16;
  localparam int Y1 = 8;
  localparam int W  = 10;

  logic       clk;
  logic       reset_n;
  logic [9:0] value;
  logic       value_valid;
  logic [9:0] x;
  logic [9:0] y;
  logic       busy_a, done_a, ovf_a, on_a;
  logic       busy_b, done_b, ovf_b, on_b;

  int n_cmp  = 0;
  int n_fail = 0;

  // Segment order a,b,c,d,e,f,g; sample point at the centre of each stroke.
  int         cx[7] = '{7, 13, 13, 7, 2, 2, 7};
  int         cy[7] = '{2, 8, 22, 29, 22, 8, 15};
  logic [6:0] seg_map[11] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                              7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40};

  numeric_display #(.X1(X1), .Y1(Y1), .DIGITS(3), .VALUE_W(W), .BLANK_LZ(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .value(value), .value_valid(value_valid),
    .x(x), .y(y), .busy(busy_a), .done(done_a), .overflow(ovf_a), .on_display(on_a));

  numeric_display #(.X1(X1), .Y1(Y1), .DIGITS(3), .VALUE_W(W), .BLANK_LZ(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .value(value), .value_valid(value_valid),
    .x(x), .y(y), .busy(busy_b), .done(done_b), .overflow(ovf_b), .on_display(on_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit model_live = 0;
  int m_value = 0;
  bit m_ovf = 0;
  bit m_busy = 0;
  bit m_done = 0;
  int m_rem = 0;
  int m_cur = 0;
  bit m_pend = 0;
  int m_pend_val = 0;

  always @(posedge clk) begin
    model_live = 1;
    if (!reset_n) begin
      m_value = 0; m_ovf = 0; m_busy = 0; m_done = 0; m_rem = 0; m_pend = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (m_pend) begin
          m_cur  = m_pend_val;
          m_pend = value_valid;
          if (value_valid) m_pend_val = int'(value);
          m_busy = 1; m_rem = W + 1;
        end else if (value_valid) begin
          m_cur  = int'(value);
          m_busy = 1; m_rem = W + 1;
        end
      end else begin
        if (value_valid) begin
          m_pend = 1; m_pend_val = int'(value);
        end
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0; m_done = 1; m_value = m_cur; m_ovf = (m_cur > 999);
        end
      end
    end
  end

  function automatic logic exp_pixel(int v, bit ovf, bit blz, int px, int py);
    int p10;
    p10 = 1;
    for (int d = 0; d < 3; d++) begin
      int gx;
      int dig, lx, ly;
      bit shown;
      gx = X1 + (2 - d) * 16;
      if (px >= gx && px < gx + 16 && py >= Y1 && py < Y1 + 32) begin
        dig   = ovf ? 10 : (v / p10) % 10;
        shown = ovf || !blz || (d == 0) || (v >= p10);
        lx    = px - gx;
        ly    = py - Y1;
        if (!shown) return 1'b0;
        for (int s = 0; s < 7; s++)
          if (lx == cx[s] && ly == cy[s]) return seg_map[dig][s];
        return 1'b0;
      end
      p10 *= 10;
    end
    return 1'b0;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_live) begin
      check("busy_a", busy_a, m_busy);
      check("busy_b", busy_b, m_busy);
      check("done_a", done_a, m_done);
      check("done_b", done_b, m_done);
      check("ovf_a", ovf_a, m_ovf);
      check("ovf_b", ovf_b, m_ovf);
      check("pix_a", on_a, exp_pixel(m_value, m_ovf, 1'b1, int'(x), int'(y)));
      check("pix_b", on_b, exp_pixel(m_value, m_ovf, 1'b0, int'(x), int'(y)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic request(input int v);
    value = 10'(v);
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int lat;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (done_a) break;
    end
    check(name, lat, 12);
    tick();
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done_a) cnt++;
    end
    tick();
  endtask

  task automatic pin(input string name, input int px, input int py, input bit ea, input bit eb);
    x = 10'(px);
    y = 10'(py);
    @(negedge clk);
    #1;
    check({name, "_a"}, on_a, ea);
    check({name, "_b"}, on_b, eb);
    tick();
  endtask

  task automatic scan_all();
    for (int d = 0; d < 3; d++) begin
      for (int p = 0; p < 8; p++) begin
        x = 10'(X1 + d * 16 + ((p < 7) ? cx[p] : 0));
        y = 10'(Y1 + ((p < 7) ? cy[p] : 0));
        tick();
      end
    end
    x = 10'd0; y = 10'd0;
    tick();
  endtask

  initial begin
    int cnt;
    reset_n = 1'b0; value = '0; value_valid = 1'b0; x = '0; y = '0;
    tick(3);
    reset_n = 1'b1;
    tick();

    // Reset content: only the ones "0" with blanking, "000" without.
    scan_all();
    pin("rst_ones_a", 55, 10, 1, 1);
    pin("rst_hund_a", 23, 10, 0, 1);
    pin("rst_ones_g", 55, 23, 0, 0);

    request(725);
    wait_done("lat_725");
    scan_all();
    pin("d725_hund_g", 23, 23, 0, 0);
    pin("d725_tens_g", 39, 23, 1, 1);
    pin("d725_ones_b", 61, 16, 0, 0);
    pin("d725_ones_f", 50, 16, 1, 1);

    request(7);
    wait_done("lat_7");
    scan_all();
    pin("d7_hund_a", 23, 10, 0, 1);
    pin("d7_tens_f", 34, 16, 0, 1);
    pin("d7_tens_g", 39, 23, 0, 0);
    pin("d7_ones_a", 55, 10, 1, 1);

    request(1000);
    wait_done("lat_1000");
    check("ovf_flag", ovf_a, 1);
    scan_all();
    pin("ovf_hund_g", 23, 23, 1, 1);
    pin("ovf_hund_a", 23, 10, 0, 0);
    pin("ovf_ones_g", 55, 23, 1, 1);

    // Last-wins pending: 456 is overwritten by 789 before it can start.
    request(123);
    tick(2);
    request(456);
    tick(2);
    request(789);
    count_done(30, cnt);
    check("pend_done_count", cnt, 2);
    scan_all();
    pin("d789_hund_a", 23, 10, 1, 1);
    pin("d789_tens_g", 39, 23, 1, 1);
    pin("d789_ones_e", 50, 30, 0, 0);
    pin("d789_ones_f", 50, 16, 1, 1);

    // Reset in the middle of a conversion discards it.
    request(500);
    tick(4);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    count_done(20, cnt);
    check("abort_done_count", cnt, 0);
    pin("abort_hund_a", 23, 10, 0, 1);
    pin("abort_ones_a", 55, 10, 1, 1);
    pin("abort_tens_g", 39, 23, 0, 0);
    scan_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
